// File: rtl/host_mem_avmm_responder.sv
// Avalon-MM host-memory responder: split read/write channels over a line-addressed RAM,
// in-order burst reads with fixed latency and burst writes with per-burst response.
module host_mem_avmm_responder #(
  parameter int DATA_WIDTH      = 512,
  parameter int MEM_ADDR_WIDTH  = 10,
  parameter int ADDR_WIDTH      = 48,
  parameter int BURST_CNT_WIDTH = 4,
  parameter int RD_CMD_DEPTH    = 8,
  parameter int RD_LATENCY      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      rd_address,
  input  logic                       rd_read,
  input  logic [BURST_CNT_WIDTH-1:0] rd_burstcount,
  output logic                       rd_waitrequest,
  output logic [DATA_WIDTH-1:0]      rd_readdata,
  output logic                       rd_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]      wr_address,
  input  logic                       wr_write,
  input  logic [BURST_CNT_WIDTH-1:0] wr_burstcount,
  input  logic [DATA_WIDTH-1:0]      wr_writedata,
  input  logic [DATA_WIDTH/8-1:0]    wr_byteenable,
  output logic                       wr_waitrequest,
  output logic                       wr_writeresponsevalid,
  output logic                       protocol_err
);
  localparam int M  = MEM_ADDR_WIDTH;
  localparam int BW = BURST_CNT_WIDTH;
  localparam int PW = $clog2(RD_CMD_DEPTH);
  localparam int BE = DATA_WIDTH / 8;
  localparam logic [BW-1:0] ONE = {{(BW-1){1'b0}}, 1'b1};

  // state    | meaning
  // WR_IDLE  | waiting for the first beat of a write burst
  // WR_BURST | accepting the remaining beats of a multi-beat burst
  typedef enum logic {WR_IDLE, WR_BURST} wr_state_t;

  logic [DATA_WIDTH-1:0] mem [2**M];
  logic [M+BW-1:0]       cmd_fifo [RD_CMD_DEPTH];
  logic [PW:0]           wp, rp;
  logic                  ready;
  logic                  fifo_full, fifo_empty, rd_accept;
  logic [M-1:0]          head_addr;
  logic [BW-1:0]         head_burst, rd_burst_eff, wr_burst_eff;
  logic                  busy, pop, issue;
  logic [M-1:0]          cur_addr, issue_addr;
  logic [BW-1:0]         remaining;
  logic [RD_LATENCY-1:0] vpipe;
  logic [DATA_WIDTH-1:0] dpipe [RD_LATENCY];
  wr_state_t             wr_state;
  logic [M-1:0]          wr_line_q, wr_line;
  logic [BW-1:0]         wr_remaining;
  logic                  wr_accept, wr_last;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{rd_address[ADDR_WIDTH-1:M], wr_address[ADDR_WIDTH-1:M]};

  assign fifo_empty     = (wp == rp);
  assign fifo_full      = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign rd_waitrequest = !ready || fifo_full;
  assign wr_waitrequest = !ready;
  assign rd_accept      = rd_read && !rd_waitrequest;
  assign wr_accept      = wr_write && !wr_waitrequest;
  assign rd_burst_eff   = (rd_burstcount == '0) ? ONE : rd_burstcount;
  assign wr_burst_eff   = (wr_burstcount == '0) ? ONE : wr_burstcount;

  // The head command issues its first beat straight from the FIFO, so an idle
  // engine starts the cycle after acceptance and bursts chain without a bubble.
  assign {head_addr, head_burst} = cmd_fifo[rp[PW-1:0]];
  assign pop        = !busy && !fifo_empty;
  assign issue      = busy || pop;
  assign issue_addr = busy ? cur_addr : head_addr;

  assign wr_line = (wr_state == WR_IDLE) ? wr_address[M-1:0] : wr_line_q;
  assign wr_last = (wr_state == WR_IDLE) ? (wr_burst_eff == ONE) : (wr_remaining == ONE);

  assign rd_readdatavalid = vpipe[RD_LATENCY-1];
  assign rd_readdata      = vpipe[RD_LATENCY-1] ? dpipe[RD_LATENCY-1] : '0;

  always_ff @(posedge clk) begin
    if (rd_accept) cmd_fifo[wp[PW-1:0]] <= {rd_address[M-1:0], rd_burst_eff};
  end

  // Read and write share one block so a same-cycle collision returns old data.
  always_ff @(posedge clk) begin
    if (issue) dpipe[0] <= mem[issue_addr];
    for (int i = 1; i < RD_LATENCY; i++) dpipe[i] <= dpipe[i-1];
    if (wr_accept) begin
      for (int b = 0; b < BE; b++) begin
        if (wr_byteenable[b]) mem[wr_line][b*8 +: 8] <= wr_writedata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready     <= 1'b0;
      wp        <= '0;
      rp        <= '0;
      busy      <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
      vpipe     <= '0;
    end else begin
      ready    <= 1'b1;
      vpipe[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) vpipe[i] <= vpipe[i-1];
      if (rd_accept) wp <= wp + 1'b1;
      if (pop) begin
        rp        <= rp + 1'b1;
        cur_addr  <= head_addr + 1'b1;
        remaining <= head_burst - ONE;
        busy      <= (head_burst != ONE);
      end else if (busy) begin
        cur_addr  <= cur_addr + 1'b1;
        remaining <= remaining - ONE;
        if (remaining == ONE) busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state              <= WR_IDLE;
      wr_line_q             <= '0;
      wr_remaining          <= '0;
      wr_writeresponsevalid <= 1'b0;
      protocol_err          <= 1'b0;
    end else begin
      wr_writeresponsevalid <= wr_accept && wr_last;
      protocol_err <= protocol_err
                    | (rd_accept && (rd_burstcount == '0))
                    | (wr_accept && (wr_state == WR_IDLE) && (wr_burstcount == '0));
      if (wr_accept) begin
        case (wr_state)
          WR_IDLE: begin
            wr_line_q    <= wr_line + 1'b1;
            wr_remaining <= wr_burst_eff - ONE;
            if (!wr_last) wr_state <= WR_BURST;
          end
          WR_BURST: begin
            wr_line_q    <= wr_line_q + 1'b1;
            wr_remaining <= wr_remaining - ONE;
            if (wr_last) wr_state <= WR_IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_host_mem_avmm_responder.sv
// Bench for host_mem_avmm_responder: a timeline model of memory, command queue and
// read-latency schedule checked every cycle, plus directed literal expectations.
module tb_host_mem_avmm_responder;
  localparam int DW = 512, MAW = 10, AW = 48, BCW = 4, DEPTH = 8, LAT = 4;
  localparam int NL = 1 << MAW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [AW-1:0]  rd_address = '0;
  logic           rd_read = 1'b0;
  logic [BCW-1:0] rd_burstcount = '0;
  logic           rd_waitrequest;
  logic [DW-1:0]  rd_readdata;
  logic           rd_readdatavalid;
  logic [AW-1:0]  wr_address = '0;
  logic           wr_write = 1'b0;
  logic [BCW-1:0] wr_burstcount = '0;
  logic [DW-1:0]  wr_writedata = '0;
  logic [DW/8-1:0] wr_byteenable = '0;
  logic           wr_waitrequest;
  logic           wr_writeresponsevalid;
  logic           protocol_err;

  host_mem_avmm_responder #(
    .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MAW), .ADDR_WIDTH(AW),
    .BURST_CNT_WIDTH(BCW), .RD_CMD_DEPTH(DEPTH), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_address(rd_address), .rd_read(rd_read), .rd_burstcount(rd_burstcount),
    .rd_waitrequest(rd_waitrequest), .rd_readdata(rd_readdata),
    .rd_readdatavalid(rd_readdatavalid),
    .wr_address(wr_address), .wr_write(wr_write), .wr_burstcount(wr_burstcount),
    .wr_writedata(wr_writedata), .wr_byteenable(wr_byteenable),
    .wr_waitrequest(wr_waitrequest), .wr_writeresponsevalid(wr_writeresponsevalid),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct { int line; int cyc; } beat_t;
  typedef struct { logic [DW-1:0] d; int cyc; } data_t;

  logic [DW-1:0] mem_m [NL];
  beat_t iss_q[$];
  data_t exp_q[$];
  data_t got_q[$];
  int    fifo_q[$];
  int    last_end = 0, resp_due = -1, wrem = 0, wline = 0;
  int    resp_cnt = 0, full_cnt = 0;
  bit    perr_m = 0, prev_rst = 1;

  // Each cycle: compare outputs against the schedule, then fold in this cycle's
  // issues (reading memory before this cycle's write), accepts and writes.
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_rd_waitrequest", rd_waitrequest, 1);
      chk("reset_wr_waitrequest", wr_waitrequest, 1);
      chk("reset_rd_readdatavalid", rd_readdatavalid, 0);
      chk("reset_rd_readdata", rd_readdata, 0);
      chk("reset_wr_writeresponsevalid", wr_writeresponsevalid, 0);
      chk("reset_protocol_err", protocol_err, 0);
      iss_q.delete(); exp_q.delete(); fifo_q.delete();
      last_end = 0; resp_due = -1; wrem = 0; perr_m = 0;
    end else begin
      bit rdy, ev;
      int bc, st;
      rdy = !prev_rst;
      while (fifo_q.size() > 0 && fifo_q[0] < cyc) void'(fifo_q.pop_front());
      chk("rd_waitrequest", rd_waitrequest, (!rdy || fifo_q.size() >= DEPTH) ? 1 : 0);
      chk("wr_waitrequest", wr_waitrequest, rdy ? 0 : 1);
      ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("rd_readdatavalid", rd_readdatavalid, ev);
      if (ev) begin
        chk("rd_readdata", rd_readdata, exp_q[0].d);
        void'(exp_q.pop_front());
      end
      chk("wr_writeresponsevalid", wr_writeresponsevalid, (resp_due == cyc) ? 1 : 0);
      chk("protocol_err", protocol_err, perr_m);
      if (rd_readdatavalid) got_q.push_back('{rd_readdata, cyc});
      if (wr_writeresponsevalid) resp_cnt++;
      if (rd_waitrequest && rdy) full_cnt++;

      while (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
        exp_q.push_back('{mem_m[iss_q[0].line], cyc + LAT});
        void'(iss_q.pop_front());
      end
      if (rd_read && !rd_waitrequest) begin
        bc = int'(rd_burstcount);
        if (bc == 0) begin bc = 1; perr_m = 1; end
        st = (cyc + 1 > last_end + 1) ? cyc + 1 : last_end + 1;
        for (int k = 0; k < bc; k++) iss_q.push_back('{(int'(rd_address[MAW-1:0]) + k) % NL, st + k});
        last_end = st + bc - 1;
        fifo_q.push_back(st);
      end
      if (wr_write && !wr_waitrequest) begin
        if (wrem == 0) begin
          wrem  = (wr_burstcount == 0) ? 1 : int'(wr_burstcount);
          if (wr_burstcount == 0) perr_m = 1;
          wline = int'(wr_address[MAW-1:0]);
        end
        for (int b = 0; b < DW/8; b++)
          if (wr_byteenable[b]) mem_m[wline][b*8 +: 8] = wr_writedata[b*8 +: 8];
        wline = (wline + 1) % NL;
        wrem--;
        if (wrem == 0) resp_due = cyc + 1;
      end
    end
    prev_rst = reset;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd_cmd(input logic [AW-1:0] a, input logic [BCW-1:0] bc, output int acc);
    bit ok = 0;
    acc = -1;
    rd_address = a; rd_burstcount = bc; rd_read = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (!rd_waitrequest) begin ok = 1; acc = cyc; end
      @(posedge clk); #1;
    end
    rd_read = 1'b0;
    if (!ok) chk("rd_accept_timeout", 0, 1);
  endtask

  task automatic wr_burst(input logic [AW-1:0] a, input int n, input logic [BCW-1:0] bc,
                          input logic [DW-1:0] d0, input logic [DW/8-1:0] be);
    for (int k = 0; k < n; k++) begin
      bit ok = 0;
      wr_write = 1'b1;
      wr_address = (k == 0) ? a : '0;
      wr_burstcount = (k == 0) ? bc : '0;
      wr_writedata = d0 + DW'(k);
      wr_byteenable = be;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge clk);
        if (!wr_waitrequest) ok = 1;
        @(posedge clk); #1;
      end
      if (!ok) chk("wr_accept_timeout", 0, 1);
    end
    wr_write = 1'b0;
  endtask

  task automatic wait_beats(input int target, input int limit);
    for (int t = 0; t < limit && got_q.size() < target; t++) step(1);
    if (got_q.size() < target) chk("beat_timeout", got_q.size(), target);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, base, r0, f0;
    logic [DW-1:0] ones, be_cleared, tag;
    ones = '1;
    be_cleared = ~(DW'(8'hFF));

    // 1: reset release
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t1_rd_wait_release_cycle", rd_waitrequest, 1);
    @(negedge clk);
    chk("t1_rd_wait_after_release", rd_waitrequest, 0);
    chk("t1_wr_wait_after_release", wr_waitrequest, 0);
    @(posedge clk); #1;

    // 2: write then read burst of 4
    r0 = resp_cnt;
    wr_burst(48'h10, 4, 4'd4, DW'(8'hA0), '1);
    step(2);
    chk("t2_resp_count", resp_cnt - r0, 1);
    base = got_q.size();
    rd_cmd(48'h10, 4'd4, acc);
    wait_beats(base + 4, 50);
    for (int k = 0; k < 4; k++) chk("t2_data", got_q[base+k].d, DW'(8'hA0 + k));
    chk("t2_latency", got_q[base].cyc - acc, 1 + LAT);

    // 3: wrap at the top line; upper address bits ignored
    wr_burst(48'h3FE, 4, 4'd4, DW'(8'hC0), '1);
    step(2);
    base = got_q.size();
    rd_cmd(48'hABCD_0000_03FE, 4'd4, acc);
    rd_cmd(48'h1, 4'd1, acc);
    wait_beats(base + 5, 60);
    for (int k = 0; k < 4; k++) chk("t3_wrap_data", got_q[base+k].d, DW'(8'hC0 + k));
    chk("t3_line1", got_q[base+4].d, DW'(8'hC3));

    // 4: nine back-to-back burst-8 reads fill the command FIFO
    for (int b = 0; b < 9; b++) begin
      tag = (DW'(16'hBEEF) << 32) | DW'(32'h100 + 8*b);
      wr_burst(48'h100 + AW'(8*b), 8, 4'd8, tag, '1);
    end
    step(2);
    base = got_q.size();
    f0 = full_cnt;
    for (int b = 0; b < 9; b++) rd_cmd(48'h100 + AW'(8*b), 4'd8, acc);
    wait_beats(base + 72, 300);
    chk("t4_waitrequest_seen", (full_cnt > f0) ? 1 : 0, 1);
    for (int i = 0; i < 72; i++)
      chk("t4_data", got_q[base+i].d, (DW'(16'hBEEF) << 32) | DW'(32'h100 + i));
    chk("t4_no_gaps", got_q[base+71].cyc - got_q[base].cyc, 71);

    // 5: byte enables and same-cycle read/write collision
    wr_burst(48'h20, 1, 4'd1, ones, '1);
    step(3);
    base = got_q.size();
    rd_cmd(48'h20, 4'd1, acc);
    wr_burst(48'h20, 1, 4'd1, '0, 64'h1);
    step(2);
    rd_cmd(48'h20, 4'd1, acc);
    wait_beats(base + 2, 50);
    chk("t5_collision_old", got_q[base].d, ones);
    chk("t5_byte0_cleared", got_q[base+1].d, be_cleared);

    // 6: reset mid-read, then a burstcount=0 read and write
    step(2);
    base = got_q.size();
    rd_cmd(48'h100, 4'd8, acc);
    wait_beats(base + 3, 50);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    r0 = got_q.size();
    step(30);
    chk("t6_no_stale_beats", got_q.size() - r0, 0);
    chk("t6_perr_clear", protocol_err, 0);
    rd_cmd(48'h3FE, 4'd0, acc);
    wait_beats(r0 + 1, 50);
    step(10);
    chk("t6_zero_burst_beats", got_q.size() - r0, 1);
    chk("t6_ram_kept", got_q[r0].d, DW'(8'hC0));
    chk("t6_perr_set", protocol_err, 1);
    wr_burst(48'h30, 1, 4'd0, DW'(8'h55), '1);
    step(3);
    chk("t6_perr_held", protocol_err, 1);

    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
